// File: rtl/wb_write_arbiter.sv
// Writeback-stage writer for the register file's single write port: merges the
// never-stalling ALU pipe with FIFO-buffered load responses and tracks pending loads.
module wb_write_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     issue_ld_valid,
    input  logic [4:0]               issue_ld_rd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     wr_enable,
    output logic [4:0]               wr_addr,
    output logic [XLEN-1:0]          wr_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LOAD = 2'd2
    } wb_src_e;

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_dead;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;

    logic             push;
    logic             pop;
    logic             alu_live;
    logic [DEPTH-1:0] occupied;
    logic [DEPTH-1:0] kill;
    logic             push_kill;
    logic [DEPTH-1:0] dead_nxt;
    logic [31:0]      pend_set;
    logic [31:0]      pend_clr;
    wb_src_e          src;
    logic [AW-1:0]    offset;

    // ld_ready reflects the count before any pop this cycle
    always_comb begin
        ld_ready = !rst && (count < CW'(DEPTH));
        push     = ld_valid && ld_ready;
        pop      = !alu_valid && (count != '0);
        alu_live = alu_valid && (alu_rd != 5'd0);
    end

    always_comb begin
        occupied = '0;
        kill     = '0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset      = AW'(AW'(i) - head);
            occupied[i] = ({1'b0, offset} < count);
            kill[i]     = alu_live && occupied[i] && !q_dead[i] && (q_rd[i] == alu_rd);
        end
        // A response arriving alongside the ALU write is still older than it
        push_kill = push && alu_live && (ld_rd == alu_rd);
    end

    always_comb begin
        dead_nxt = q_dead | kill;
        if (push) begin
            dead_nxt[tail] = push_kill;
        end
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_ld_valid && (issue_ld_rd != 5'd0)) begin
            pend_set[issue_ld_rd] = 1'b1;
        end
        if (pop && (q_rd[head] != 5'd0)) begin
            pend_clr[q_rd[head]] = 1'b1;
        end
        if ((|kill) || push_kill) begin
            pend_clr[alu_rd] = 1'b1;
        end
    end

    always_comb begin
        src = SRC_NONE;
        if (alu_valid) begin
            src = SRC_ALU;
        end else if (pop) begin
            src = SRC_LOAD;
        end
    end

    // Payload storage needs no reset; occupancy is governed by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= ld_rd;
            q_data[tail] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            q_dead       <= '0;
            pending_mask <= '0;
        end else begin
            q_dead       <= dead_nxt;
            pending_mask <= (pending_mask & ~pend_clr) | pend_set;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_enable <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            case (src)
                SRC_ALU: begin
                    wr_enable <= alu_live;
                    wr_addr   <= alu_rd;
                    wr_data   <= alu_data;
                end
                SRC_LOAD: begin
                    wr_enable <= !q_dead[head] && (q_rd[head] != 5'd0);
                    wr_addr   <= q_rd[head];
                    wr_data   <= q_data[head];
                end
                default: begin
                    wr_enable <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_count = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with hand-computed expectations.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        issue_ld_valid;
    logic [4:0]  issue_ld_rd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    wb_write_arbiter #(.XLEN(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .issue_ld_valid(issue_ld_valid), .issue_ld_rd(issue_ld_rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        issue_ld_valid = 1'b0; issue_ld_rd = '0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'hDEAD;

        // Reset with a load response presented
        tick(); tick();
        chk("rst_wr_enable", 64'(wr_enable), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_pending", 64'(pending_mask), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        rst = 1'b0; ld_valid = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ld_ready), 64'd1);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        tick();
        chk("alu_wr_enable", 64'(wr_enable), 64'd1);
        chk("alu_wr_addr", 64'(wr_addr), 64'd5);
        chk("alu_wr_data", wr_data, 64'h1234);
        alu_rd = 5'd0; alu_data = 64'h99;
        tick();
        chk("alu_x0_wr_enable", 64'(wr_enable), 64'd0);
        alu_valid = 1'b0;
        tick();
        chk("idle_wr_enable", 64'(wr_enable), 64'd0);

        // Single load
        issue_ld_valid = 1'b1; issue_ld_rd = 5'd7;
        tick();
        issue_ld_valid = 1'b0;
        chk("ld_pending_set", 64'(pending_mask), 64'h80);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'hAA;
        tick();
        ld_valid = 1'b0;
        chk("ld_push_count", 64'(fifo_count), 64'd1);
        chk("ld_push_no_write", 64'(wr_enable), 64'd0);
        tick();
        chk("ld_wr_enable", 64'(wr_enable), 64'd1);
        chk("ld_wr_addr", 64'(wr_addr), 64'd7);
        chk("ld_wr_data", wr_data, 64'hAA);
        chk("ld_pending_clr", 64'(pending_mask), 64'd0);
        chk("ld_pop_count", 64'(fifo_count), 64'd0);

        // Contention: ALU busy for 5 cycles while loads arrive
        for (int unsigned i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 64'(i + 1);
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 64'(16'h100 + i);
            #1;
            chk("cont_ready", 64'(ld_ready), (i < 4) ? 64'd1 : 64'd0);
            tick();
            chk("cont_alu_addr", 64'(wr_addr), 64'(20 + i));
            chk("cont_count", 64'(fifo_count), (i < 4) ? 64'(i + 1) : 64'd4);
        end
        alu_valid = 1'b0;
        #1;
        chk("cont_full_ready", 64'(ld_ready), 64'd0);
        tick();
        chk("drain0_addr", 64'(wr_addr), 64'd10);
        chk("drain0_data", wr_data, 64'h100);
        chk("drain0_count", 64'(fifo_count), 64'd3);
        tick();
        ld_valid = 1'b0;
        chk("drain1_addr", 64'(wr_addr), 64'd11);
        chk("drain1_count", 64'(fifo_count), 64'd3);
        for (int unsigned i = 2; i < 5; i++) begin
            tick();
            chk("drain_en", 64'(wr_enable), 64'd1);
            chk("drain_addr", 64'(wr_addr), 64'(10 + i));
            chk("drain_data", wr_data, 64'(16'h100 + i));
        end
        chk("drain_empty", 64'(fifo_count), 64'd0);
        tick();
        chk("drain_idle", 64'(wr_enable), 64'd0);

        // WAW kill of a queued load
        issue_ld_valid = 1'b1; issue_ld_rd = 5'd3;
        tick();
        issue_ld_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h77;
        tick();
        ld_valid = 1'b0;
        chk("waw_pending", 64'(pending_mask), 64'h8);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h55;
        tick();
        alu_valid = 1'b0;
        chk("waw_alu_en", 64'(wr_enable), 64'd1);
        chk("waw_alu_data", wr_data, 64'h55);
        chk("waw_pending_clr", 64'(pending_mask), 64'd0);
        chk("waw_count_kept", 64'(fifo_count), 64'd1);
        tick();
        chk("waw_dead_pop_en", 64'(wr_enable), 64'd0);
        chk("waw_dead_pop_count", 64'(fifo_count), 64'd0);
        chk("waw_pending_after", 64'(pending_mask), 64'd0);

        // Mid-run reset with three queued entries
        issue_ld_valid = 1'b1; issue_ld_rd = 5'd3;
        tick();
        issue_ld_rd = 5'd7;
        tick();
        issue_ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
        ld_valid = 1'b1;
        ld_rd = 5'd3; tick();
        ld_rd = 5'd7; tick();
        ld_rd = 5'd9; tick();
        chk("mid_count", 64'(fifo_count), 64'd3);
        chk("mid_pending", 64'(pending_mask), 64'h88);
        rst = 1'b1; issue_ld_valid = 1'b1; issue_ld_rd = 5'd4;
        tick();
        rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; issue_ld_valid = 1'b0;
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_pending", 64'(pending_mask), 64'd0);
        chk("mid_rst_en", 64'(wr_enable), 64'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_write", 64'(wr_enable), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
